// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Fills the instruction memory with a program before the CPU runs. A byte
//   stream (valid/ready) is packed big-endian, four bytes to a word. Each word
//   is written at BASE_ADDR, BASE_ADDR+4, ... (same +4 stride as the PC). The
//   CPU is held while the load is in progress, and done pulses once at the end.
//
// Ports
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   start          : one-cycle load request, sampled only in IDLE
//   word_count     : words to load, sampled with start (clamped to MAX_WORDS)
//   abort          : cancel the load from any state
//   in_data/in_valid/in_ready : byte stream handshake
//   wr_en/wr_addr/wr_data     : instruction-memory write port
//   cpu_hold       : stalls the PC and datapath while a load is running
//   done           : one-cycle pulse when a load completes normally
//   words_written  : words written in the current or last load
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int                 MAX_WORDS = 256,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic [CNT_W-1:0]  words_written
);

    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  words_left_q, words_left_d;
    logic [CNT_W-1:0]  words_written_q, words_written_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            byte_idx_q      <= '0;
            word_q          <= '0;
            addr_q          <= BASE_ADDR;
            words_left_q    <= '0;
            words_written_q <= '0;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= BASE_ADDR;
            wr_data_q       <= '0;
        end else begin
            state_q         <= state_d;
            byte_idx_q      <= byte_idx_d;
            word_q          <= word_d;
            addr_q          <= addr_d;
            words_left_q    <= words_left_d;
            words_written_q <= words_written_d;
            wr_en_q         <= wr_en_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        byte_idx_d      = byte_idx_q;
        word_d          = word_q;
        addr_d          = addr_q;
        words_left_d    = words_left_q;
        words_written_d = words_written_q;
        wr_en_d         = 1'b0;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;

        if (abort) begin
            // Drop the partial word; completed writes stay counted.
            state_d    = S_IDLE;
            byte_idx_d = '0;
            word_d     = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        words_written_d = '0;
                        if (word_count != '0) begin
                            state_d      = S_RECV;
                            words_left_d = (word_count > MAX_CNT) ? MAX_CNT : word_count;
                            addr_d       = BASE_ADDR;
                            byte_idx_d   = '0;
                            word_d       = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_RECV: begin
                    // in_ready is high for the whole of RECV, so in_valid alone
                    // marks an accepted byte. Byte 0 lands in [31:24].
                    if (in_valid) begin
                        word_d[{~byte_idx_q, 3'b000} +: 8] = in_data;
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            // Register the write so it is on the port during WRITE.
                            state_d   = S_WRITE;
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = word_d;
                        end
                    end
                end
                S_WRITE: begin
                    addr_d          = addr_q + WORD_STEP;
                    words_written_d = words_written_q + CNT_W'(1);
                    words_left_d    = words_left_q - CNT_W'(1);
                    byte_idx_d      = '0;
                    state_d         = (words_left_q == CNT_W'(1)) ? S_DONE : S_RECV;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign in_ready      = (state_q == S_RECV);
    assign cpu_hold      = (state_q == S_RECV) || (state_q == S_WRITE);
    assign done          = (state_q == S_DONE);
    // The write strobe is registered, but an abort arriving in the write cycle
    // must still cancel the memory write, hence the gate.
    assign wr_en         = wr_en_q & ~abort;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign words_written = words_written_q;

endmodule
